// File: rtl/fft_pkg.sv
// Shared widths and the per-stage record for the FFT magnitude square-root pipeline.
package fft_pkg;

    localparam int FFT_W    = 16;
    localparam int MAG_SQ_W = 2*FFT_W + 1;
    localparam int ROOT_W   = FFT_W + 1;
    localparam int REM_W    = FFT_W + 2;
    localparam int SQRT_LAT = FFT_W + 1;
    localparam int RAD_W    = 2*ROOT_W;

    typedef struct packed {
        logic              valid;
        logic [RAD_W-1:0]  radicand;
        logic [ROOT_W-1:0] q;
        logic [REM_W-1:0]  r;
    } sqrt_stage_t;

endpackage

// File: rtl/fft_sqrt_stage.sv
// One registered restoring square-root iteration: consumes radicand bit-pair K (MSB pair first).
module fft_sqrt_stage
    import fft_pkg::*;
#(
    parameter int W = FFT_W,
    parameter int K = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  sqrt_stage_t stage_in,
    output sqrt_stage_t stage_out
);

    localparam int PAIR_LSB = 2*(W - K);

    logic [1:0]       pair;
    logic [REM_W+1:0] r_shift;
    logic [REM_W+1:0] trial;
    logic             fits;
    sqrt_stage_t      stage_d;

    always_comb begin
        pair    = stage_in.radicand[PAIR_LSB +: 2];
        r_shift = {stage_in.r, pair};
        trial   = {{(REM_W-ROOT_W){1'b0}}, stage_in.q, 2'b01};
        fits    = (r_shift >= trial);
        stage_d = stage_in;
        stage_d.q = (stage_in.q << 1) | ROOT_W'(fits);
        // The restored remainder never exceeds 2q, so it always fits back into REM_W bits.
        if (fits) begin
            stage_d.r = REM_W'(r_shift - trial);
        end else begin
            stage_d.r = REM_W'(r_shift);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_out <= '0;
        end else begin
            stage_out <= stage_d;
        end
    end

endmodule

// File: rtl/fft_mag_sqrt.sv
// Fully pipelined integer square root of the magnitude-squared stream: root = floor(sqrt(mag_sq)), rem = mag_sq - root^2.
module fft_mag_sqrt
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mag_valid,
    input  logic [2*W:0] mag_sq,
    output logic [W:0]   root,
    output logic [W+1:0] rem,
    output logic         root_valid
);

    sqrt_stage_t seed_p0;
    sqrt_stage_t stage_p [0:SQRT_LAT-1];
    logic        radicand_unused;

    // Input capture: zero-extended radicand, iteration seeded with q=0, r=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_p0 <= '0;
        end else begin
            seed_p0 <= '{valid: mag_valid, radicand: RAD_W'(mag_sq), q: '0, r: '0};
        end
    end

    for (genvar k = 0; k < SQRT_LAT; k++) begin : g_stage
        if (k == 0) begin : g_first
            fft_sqrt_stage #(.W(W), .K(k)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .stage_in  (seed_p0),
                .stage_out (stage_p[k])
            );
        end else begin : g_next
            fft_sqrt_stage #(.W(W), .K(k)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .stage_in  (stage_p[k-1]),
                .stage_out (stage_p[k])
            );
        end
    end

    assign root            = stage_p[SQRT_LAT-1].q;
    assign rem             = stage_p[SQRT_LAT-1].r;
    assign root_valid      = stage_p[SQRT_LAT-1].valid;
    assign radicand_unused = ^stage_p[SQRT_LAT-1].radicand;

endmodule

// File: tb/tb_fft_mag_sqrt.sv
// Directed-vector and randomized bench for the pipelined magnitude square root.
module tb_fft_mag_sqrt;

    localparam int LAT = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        mag_valid;
    logic [32:0] mag_sq;
    logic [16:0] root;
    logic [17:0] rem;
    logic        root_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [32:0] mag_sq;
        logic [16:0] root;
        logic [17:0] rem;
    } vec_t;

    vec_t vecs [13];

    logic        seq_v [16];
    logic [32:0] seq_d [16];
    logic [16:0] seq_r [16];
    logic [17:0] seq_m [16];

    logic [32:0] rq [$];

    fft_mag_sqrt dut (
        .clk        (clk),
        .reset      (reset),
        .mag_valid  (mag_valid),
        .mag_sq     (mag_sq),
        .root       (root),
        .rem        (rem),
        .root_valid (root_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_seq(input int i, input logic v, input logic [32:0] d,
                           input logic [16:0] r, input logic [17:0] m);
        seq_v[i] = v;
        seq_d[i] = d;
        seq_r[i] = r;
        seq_m[i] = m;
    endtask

    // Drives seq[0..n-1] on consecutive edges and checks every output slot, including idle ones.
    task automatic run_seq(input int n, input string tag);
        int j;
        for (int i = 0; i < n + LAT + 2; i++) begin
            mag_valid = (i < n) ? seq_v[i] : 1'b0;
            mag_sq    = (i < n) ? seq_d[i] : 33'h0_1234_5678;
            @(posedge clk);
            #1;
            j = i - LAT;
            if (j >= 0 && j < n) begin
                check({tag, " valid"}, 64'(root_valid), 64'(seq_v[j]));
                if (seq_v[j]) begin
                    check({tag, " root"}, 64'(root), 64'(seq_r[j]));
                    check({tag, " rem"}, 64'(rem), 64'(seq_m[j]));
                end
            end else begin
                check({tag, " idle"}, 64'(root_valid), 64'd0);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{33'd0,          17'd0,     18'd0};
        vecs[1]  = '{33'd1,          17'd1,     18'd0};
        vecs[2]  = '{33'd3,          17'd1,     18'd2};
        vecs[3]  = '{33'd4,          17'd2,     18'd0};
        vecs[4]  = '{33'd15,         17'd3,     18'd6};
        vecs[5]  = '{33'd65536,      17'd256,   18'd0};
        vecs[6]  = '{33'd32344189,   17'd5687,  18'd2220};
        vecs[7]  = '{33'd1452565792, 17'd38112, 18'd41248};
        vecs[8]  = '{33'd2147483648, 17'd46340, 18'd88048};
        vecs[9]  = '{33'd4294967295, 17'd65535, 18'd131070};
        vecs[10] = '{33'd4294967296, 17'd65536, 18'd0};
        vecs[11] = '{33'd8589934591, 17'd92681, 18'd166830};
        vecs[12] = '{33'd8589767761, 17'd92681, 18'd0};

        // Reset held, then released with an idle input stream.
        reset     = 1'b0;
        mag_valid = 1'b0;
        mag_sq    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 64'(root_valid), 64'd0);
        check("reset root", 64'(root), 64'd0);
        check("reset rem", 64'(rem), 64'd0);
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle valid", 64'(root_valid), 64'd0);
            check("idle root", 64'(root), 64'd0);
            check("idle rem", 64'(rem), 64'd0);
        end

        // Single samples with exact latency.
        for (int v = 0; v < 13; v++) begin
            set_seq(0, 1'b1, vecs[v].mag_sq, vecs[v].root, vecs[v].rem);
            run_seq(1, $sformatf("vec%0d", v));
        end

        // Back-to-back samples.
        set_seq(0, 1'b1, 33'd0,          17'd0,     18'd0);
        set_seq(1, 1'b1, 33'd1,          17'd1,     18'd0);
        set_seq(2, 1'b1, 33'd32344189,   17'd5687,  18'd2220);
        set_seq(3, 1'b1, 33'd2147483648, 17'd46340, 18'd88048);
        run_seq(4, "b2b");

        // Bubbles in the input stream.
        set_seq(0, 1'b1, 33'd4,           17'd2, 18'd0);
        set_seq(1, 1'b0, 33'h1_DEAD_BEEF, 17'd0, 18'd0);
        set_seq(2, 1'b1, 33'd9,           17'd3, 18'd0);
        set_seq(3, 1'b1, 33'd15,          17'd3, 18'd6);
        set_seq(4, 1'b0, 33'h0_CAFE_F00D, 17'd0, 18'd0);
        run_seq(5, "bubble");

        // Reset pulse with samples in flight: first one has emerged, five are still inside.
        for (int i = 0; i < 6; i++) begin
            mag_valid = 1'b1;
            mag_sq    = 33'(100 * (i + 1) * (i + 1));
            @(posedge clk);
            #1;
        end
        mag_valid = 1'b0;
        repeat (LAT - 5) @(posedge clk);
        #1;
        check("pre-pulse valid", 64'(root_valid), 64'd1);
        check("pre-pulse root", 64'(root), 64'd10);
        #2 reset = 1'b0;
        #1;
        check("pulse valid", 64'(root_valid), 64'd0);
        check("pulse root", 64'(root), 64'd0);
        check("pulse rem", 64'(rem), 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("flushed valid", 64'(root_valid), 64'd0);
        end
        set_seq(0, 1'b1, 33'd144, 17'd12, 18'd0);
        set_seq(1, 1'b1, 33'd145, 17'd12, 18'd1);
        run_seq(2, "post-pulse");

        // Random stream with bubbles, checked against the square-root identity in input order.
        for (int i = 0; i < 10000 + LAT + 3; i++) begin
            logic        v;
            logic [32:0] d;
            longint      rr;
            longint      mm;
            logic [32:0] e;
            v = (i < 10000) && ($urandom_range(3, 0) != 0);
            case ($urandom_range(3, 0))
                0:       d = 33'($urandom_range(1000, 0));
                1:       d = 33'h1_FFFF_FFFF - 33'($urandom_range(1000, 0));
                default: d = {1'($urandom_range(1, 0)), 32'($urandom())};
            endcase
            mag_valid = v;
            mag_sq    = d;
            if (v) rq.push_back(d);
            @(posedge clk);
            #1;
            if (root_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    check("rand spurious output", 64'(root_valid), 64'd0);
                end else begin
                    e  = rq.pop_front();
                    rr = longint'(root);
                    mm = longint'(rem);
                    check("rand root^2+rem", 64'(rr * rr + mm), 64'(e));
                    check("rand rem<=2root", 64'(mm <= 2 * rr), 64'd1);
                end
            end
        end
        check("rand leftover", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
